// File: rtl/dmem_responder_pkg.sv
// Shared CPU profile constants and types for the data-memory responder.
`timescale 1ns/1ps
package dmem_responder_pkg;

  localparam int          XLEN       = 32;
  localparam int          NUM_BE     = XLEN / 8;
  localparam int          ADDR_SHIFT = 2;
  localparam logic [31:0] IMEM_BYTES = 32'h0004_0000;
  localparam logic [31:0] DMEM_BASE  = IMEM_BYTES;
  localparam int          DMEM_SIZE  = 256;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [NUM_BE-1:0] be;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Out of range (below base or past the last word) or not word aligned.
  function automatic logic addr_err(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] base,
                                    input int unsigned     depth);
    logic [XLEN-1:0] word_idx;
    word_idx = (addr - base) >> ADDR_SHIFT;
    return (addr < base) || (word_idx >= XLEN'(depth)) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous data RAM with per-byte write enables and a registered read port.
`timescale 1ns/1ps
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_SIZE,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [NUM_BE-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read returns the pre-write word; only loads consume rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NUM_BE; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed-latency valid/ready response out.
// state | meaning
// IDLE  | no transaction, ready for a request
// WAIT  | request accepted, latency counter running
// RESP  | response presented, waiting for rsp_ready
`timescale 1ns/1ps
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = DMEM_SIZE,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int          LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [NUM_BE-1:0] req_be,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  dmem_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, ld_q;
  logic            accept, req_err;
  logic [XLEN-1:0] word_off;
  logic [XLEN-1:0] ram_rdata;
  mem_req_t        req;
  mem_rsp_t        rsp;

  assign req      = '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata};
  assign req_err  = addr_err(req.addr, BASE_ADDR, DEPTH);
  assign word_off = (req.addr - BASE_ADDR) >> ADDR_SHIFT;

  // Gated by rst_n so nothing is accepted (or written) while reset is held.
  assign req_ready = rst_n && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (accept && !req_err),
    .we    (req.we ? req.be : '0),
    .addr  (word_off[AW-1:0]),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q <= req_err;
        ld_q  <= !req.we && !req_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else if (state_q == RESP && rsp_ready) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM output register holds load data until the next accepted request.
  assign rsp_valid = (state_q == RESP);
  assign rsp.rdata = (rsp_valid && ld_q) ? ram_rdata : '0;
  assign rsp.err   = rsp_valid && err_q;
  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> ($stable(rsp_rdata) && $stable(rsp_err)));

  a_wait_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == WAIT) |-> !req_ready);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1 (a), one at LATENCY=4 (b).
`timescale 1ns/1ps
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] B = DMEM_BASE;
  localparam int          D = DMEM_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_a = 0, req_ready_a, req_we_a = 0, rsp_valid_a, rsp_ready_a = 1, rsp_err_a;
  logic [31:0] req_addr_a = 0, req_wdata_a = 0, rsp_rdata_a;
  logic [3:0]  req_be_a = 0;
  logic        req_valid_b = 0, req_ready_b, req_we_b = 0, rsp_valid_b, rsp_ready_b = 1, rsp_err_b;
  logic [31:0] req_addr_b = 0, req_wdata_b = 0, rsp_rdata_b;
  logic [3:0]  req_be_b = 0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we_a), .req_addr(req_addr_a), .req_be(req_be_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  dmem_responder #(.LATENCY(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we_b), .req_addr(req_addr_b), .req_be(req_be_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  // Present a request and return at acceptance edge + 1ns; sel=0 -> dut a, sel=1 -> dut b.
  task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    bit rdy;
    bit done;
    done = 0;
    if (sel) begin
      req_we_b = we; req_addr_b = addr; req_be_b = be; req_wdata_b = wdata; req_valid_b = 1;
    end else begin
      req_we_a = we; req_addr_a = addr; req_be_a = be; req_wdata_a = wdata; req_valid_a = 1;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = sel ? req_ready_b : req_ready_a;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    req_valid_a = 0;
    req_valid_b = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout sel=%0d addr=%h: request not accepted in 20 cycles", sel, addr);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready_a !== 1'b0 || req_ready_b !== 1'b0) begin errors++;
      $display("FAIL reset_req_ready got a=%b b=%b want 0", req_ready_a, req_ready_b); end
    checks++; if (rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid got a=%b b=%b want 0", rsp_valid_a, rsp_valid_b); end
    checks++; if (rsp_rdata_a !== 32'h0 || rsp_err_a !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_fields got rdata=%h err=%b want 0/0", rsp_rdata_a, rsp_err_a); end
    rst_n = 1;
    #1;
    checks++; if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1) begin errors++;
      $display("FAIL release_req_ready got a=%b b=%b want 1", req_ready_a, req_ready_b); end
  endtask

  task automatic test_store_load;
    issue(0, 1, B + 8, 4'hF, 32'hDEADBEEF);
    checks++; if (rsp_valid_a !== 1'b1 || rsp_err_a !== 1'b0 || rsp_rdata_a !== 32'h0) begin errors++;
      $display("FAIL store_rsp got v=%b err=%b rdata=%h want 1/0/0", rsp_valid_a, rsp_err_a, rsp_rdata_a); end
    issue(0, 0, B + 8, 4'h0, 32'h0);
    checks++; if (rsp_valid_a !== 1'b1 || rsp_err_a !== 1'b0 || rsp_rdata_a !== 32'hDEADBEEF) begin errors++;
      $display("FAIL load_rsp got v=%b err=%b rdata=%h want 1/0/deadbeef", rsp_valid_a, rsp_err_a, rsp_rdata_a); end
    @(posedge clk); #1;
    checks++; if (rsp_valid_a !== 1'b0) begin errors++;
      $display("FAIL idle_after_handshake got rsp_valid=%b want 0", rsp_valid_a); end
  endtask

  task automatic test_byte_lanes;
    issue(0, 1, B + 12, 4'hF, 32'h11223344);
    issue(0, 1, B + 12, 4'b0101, 32'hAABBCCDD);
    issue(0, 0, B + 12, 4'hF, 32'h0);
    checks++; if (rsp_rdata_a !== 32'h11BB33DD || rsp_err_a !== 1'b0) begin errors++;
      $display("FAIL byte_lanes got rdata=%h err=%b want 11bb33dd/0", rsp_rdata_a, rsp_err_a); end
  endtask

  task automatic test_back_to_back;
    req_we_a = 0; req_addr_a = B + 8; req_be_a = 0; req_valid_a = 1;
    checks++; if (req_ready_a !== 1'b1) begin errors++;
      $display("FAIL b2b_ready got %b want 1", req_ready_a); end
    @(posedge clk); #1;
    checks++; if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== 32'hDEADBEEF || req_ready_a !== 1'b1) begin errors++;
      $display("FAIL b2b_first got v=%b rdata=%h rdy=%b want 1/deadbeef/1", rsp_valid_a, rsp_rdata_a, req_ready_a); end
    req_addr_a = B + 12;
    @(posedge clk); #1;
    req_valid_a = 0;
    checks++; if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== 32'h11BB33DD) begin errors++;
      $display("FAIL b2b_second got v=%b rdata=%h want 1/11bb33dd", rsp_valid_a, rsp_rdata_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors;
    issue(0, 1, B, 4'hF, 32'h0BADF00D);
    issue(0, 1, B + 4 * (D - 1), 4'hF, 32'h5A5A5A5A);
    issue(0, 0, B + 2, 4'hF, 32'h0);
    checks++; if (rsp_err_a !== 1'b1 || rsp_rdata_a !== 32'h0) begin errors++;
      $display("FAIL misaligned got err=%b rdata=%h want 1/0", rsp_err_a, rsp_rdata_a); end
    issue(0, 0, B + 4 * D, 4'hF, 32'h0);
    checks++; if (rsp_err_a !== 1'b1 || rsp_rdata_a !== 32'h0) begin errors++;
      $display("FAIL past_end got err=%b rdata=%h want 1/0", rsp_err_a, rsp_rdata_a); end
    issue(0, 1, B - 4, 4'hF, 32'hFFFFFFFF);
    checks++; if (rsp_err_a !== 1'b1) begin errors++;
      $display("FAIL below_base got err=%b want 1", rsp_err_a); end
    issue(0, 0, B, 4'hF, 32'h0);
    checks++; if (rsp_err_a !== 1'b0 || rsp_rdata_a !== 32'h0BADF00D) begin errors++;
      $display("FAIL word0_kept got err=%b rdata=%h want 0/0badf00d", rsp_err_a, rsp_rdata_a); end
    issue(0, 0, B + 4 * (D - 1), 4'hF, 32'h0);
    checks++; if (rsp_rdata_a !== 32'h5A5A5A5A) begin errors++;
      $display("FAIL last_word_kept got rdata=%h want 5a5a5a5a", rsp_rdata_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int  n;
    bit  rdy_seen;
    issue(1, 1, B + 16, 4'hF, 32'hCAFEF00D);
    issue(1, 0, B + 16, 4'hF, 32'h0);
    n = 1; rdy_seen = 0;
    while (!rsp_valid_b && n < 20) begin
      if (req_ready_b !== 1'b0) rdy_seen = 1;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 4) begin errors++;
      $display("FAIL lat4_cycles got %0d want 4", n); end
    checks++; if (rdy_seen) begin errors++;
      $display("FAIL lat4_wait_ready got req_ready=1 in WAIT want 0"); end
    checks++; if (rsp_rdata_b !== 32'hCAFEF00D || rsp_err_b !== 1'b0) begin errors++;
      $display("FAIL lat4_data got rdata=%h err=%b want cafef00d/0", rsp_rdata_b, rsp_err_b); end
  endtask

  task automatic test_stall;
    int n;
    bit bad;
    issue(1, 1, B + 20, 4'hF, 32'h12345678);
    issue(1, 0, B + 16, 4'hF, 32'h0);
    rsp_ready_b = 0;
    n = 0;
    while (!rsp_valid_b && n < 20) begin @(posedge clk); #1; n++; end
    req_we_b = 0; req_addr_b = B + 20; req_be_b = 0; req_valid_b = 1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_b !== 1'b1 || rsp_rdata_b !== 32'hCAFEF00D || rsp_err_b !== 1'b0 || req_ready_b !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++;
      $display("FAIL stall_hold got v=%b rdata=%h err=%b rdy=%b want 1/cafef00d/0/0",
               rsp_valid_b, rsp_rdata_b, rsp_err_b, req_ready_b); end
    rsp_ready_b = 1;
    #1;
    checks++; if (req_ready_b !== 1'b1) begin errors++;
      $display("FAIL stall_release_ready got %b want 1", req_ready_b); end
    @(posedge clk); #1;
    req_valid_b = 0;
    checks++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b0) begin errors++;
      $display("FAIL stall_b2b_accept got v=%b rdy=%b want 0/0", rsp_valid_b, req_ready_b); end
    n = 1;
    while (!rsp_valid_b && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 4 || rsp_rdata_b !== 32'h12345678) begin errors++;
      $display("FAIL stall_next_rsp got n=%0d rdata=%h want 4/12345678", n, rsp_rdata_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit seen;
    issue(1, 0, B + 16, 4'hF, 32'h0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b0) begin errors++;
      $display("FAIL midrst_asserted got v=%b rdy=%b want 0/0", rsp_valid_b, req_ready_b); end
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    checks++; if (req_ready_b !== 1'b1) begin errors++;
      $display("FAIL midrst_release_ready got %b want 1", req_ready_b); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_b !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++;
      $display("FAIL midrst_dropped got rsp_valid=1 want no response"); end
    issue(1, 0, B + 20, 4'hF, 32'h0);
    while (!rsp_valid_b && checks < 1000) begin @(posedge clk); #1; checks++; end
    checks++; if (rsp_valid_b !== 1'b1 || rsp_rdata_b !== 32'h12345678) begin errors++;
      $display("FAIL midrst_store_kept got v=%b rdata=%h want 1/12345678", rsp_valid_b, rsp_rdata_b); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_latency();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
